// File: rtl/ph_alarm_monitor.sv
// ---------------------------------------------------------------------------
// ph_alarm_monitor
//   Downstream stage of the blood pH analyzer. The alarm is raised only
//   after PERSIST consecutive abnormal samples, so single-sample glitches do
//   not trigger it. The alarm and its cause are latched until a nurse
//   acknowledge. The block counts alarm events for the monitoring panel.
//
// Parameters
//   PERSIST  consecutive abnormal samples needed to raise the alarm (1..15)
//   CLEAR    consecutive normal samples needed to re-arm (1..15)
//   CNT_W    width of eventCount
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   sampleValid   one-cycle strobe, abnormality flags valid this cycle
//   abnormalityP  analyzer abnormality flag P
//   abnormalityQ  analyzer abnormality flag Q
//   alarmAck      acknowledge pulse, honoured only in ALARM
//   alarm         alarm active (registered)
//   alarmCode     {Q,P} sticky cause since arming began (registered)
//   armed         high only in IDLE (registered)
//   eventCount    number of ARMING->ALARM transitions, saturating
//
// Configuration
//   PH_ALARM_AUTOCLEAR_EN : when defined, CLEAR consecutive normal samples
//   in ALARM return the block to IDLE without an acknowledge.
// ---------------------------------------------------------------------------
module ph_alarm_monitor #(
  parameter int PERSIST = 3,
  parameter int CLEAR   = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sampleValid,
  input  logic             abnormalityP,
  input  logic             abnormalityQ,
  input  logic             alarmAck,
  output logic             alarm,
  output logic [1:0]       alarmCode,
  output logic             armed,
  output logic [CNT_W-1:0] eventCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    ALARM  = 2'd2,
    ACKED  = 2'd3
  } stateT;

  localparam logic [3:0] PERSIST_C = 4'(PERSIST);
  localparam logic [3:0] CLEAR_C   = 4'(CLEAR);

  // Saturating increment: an all-ones count stays at all-ones.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  stateT            state;
  stateT            stateNext;
  logic [3:0]       runCnt;
  logic [3:0]       runNext;
  logic [3:0]       okCnt;
  logic [3:0]       okNext;
  logic [1:0]       codeNext;
  logic [CNT_W-1:0] eventNext;

  logic       abnormalSample;
  logic       normalSample;
  logic [1:0] sampleCode;
  logic [3:0] runInc;
  logic [3:0] okInc;

  // Sample classification and counter increments shared by all states.
  always_comb begin
    abnormalSample = sampleValid & (abnormalityP | abnormalityQ);
    normalSample   = sampleValid & ~(abnormalityP | abnormalityQ);
    sampleCode     = {abnormalityQ, abnormalityP};
    runInc         = runCnt + 4'd1;
    okInc          = okCnt + 4'd1;
  end

  // Next-state and next-output computation.
  always_comb begin
    stateNext = state;
    runNext   = runCnt;
    okNext    = okCnt;
    codeNext  = alarmCode;
    eventNext = eventCount;
    case (state)
      IDLE: begin
        if (abnormalSample) begin
          runNext  = 4'd1;
          codeNext = sampleCode;
          if (PERSIST_C == 4'd1) begin
            stateNext = ALARM;
            okNext    = 4'd0;
          end else begin
            stateNext = ARMING;
          end
        end else begin
          stateNext = IDLE;
        end
      end
      ARMING: begin
        if (abnormalSample) begin
          runNext  = runInc;
          codeNext = alarmCode | sampleCode;
          if (runInc == PERSIST_C) begin
            stateNext = ALARM;
            okNext    = 4'd0;
            eventNext = satInc(eventCount);
          end else begin
            stateNext = ARMING;
          end
        end else if (normalSample) begin
          stateNext = IDLE;
          runNext   = 4'd0;
          codeNext  = 2'b00;
        end else begin
          stateNext = ARMING;
        end
      end
      ALARM: begin
`ifdef PH_ALARM_AUTOCLEAR_EN
        // Auto-clear completion takes priority over a simultaneous ack.
        if (normalSample && (okInc == CLEAR_C)) begin
          stateNext = IDLE;
          runNext   = 4'd0;
          okNext    = 4'd0;
          codeNext  = 2'b00;
        end else if (alarmAck) begin
          stateNext = ACKED;
          okNext    = 4'd0;
        end else if (abnormalSample) begin
          codeNext = alarmCode | sampleCode;
          okNext   = 4'd0;
        end else if (normalSample) begin
          okNext = okInc;
        end else begin
          stateNext = ALARM;
        end
`else
        // A sample arriving together with the ack is dropped.
        if (alarmAck) begin
          stateNext = ACKED;
          okNext    = 4'd0;
        end else if (abnormalSample) begin
          codeNext = alarmCode | sampleCode;
        end else begin
          stateNext = ALARM;
        end
`endif
      end
      ACKED: begin
        if (normalSample) begin
          if (okInc == CLEAR_C) begin
            stateNext = IDLE;
            runNext   = 4'd0;
            okNext    = 4'd0;
            codeNext  = 2'b00;
          end else begin
            okNext = okInc;
          end
        end else if (abnormalSample) begin
          okNext = 4'd0;
        end else begin
          stateNext = ACKED;
        end
      end
      default: begin
        stateNext = IDLE;
        runNext   = 4'd0;
        okNext    = 4'd0;
        codeNext  = 2'b00;
      end
    endcase
  end

  // State, counters and registered outputs; outputs reflect the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      runCnt     <= 4'd0;
      okCnt      <= 4'd0;
      alarm      <= 1'b0;
      alarmCode  <= 2'b00;
      armed      <= 1'b1;
      eventCount <= {CNT_W{1'b0}};
    end else begin
      state      <= stateNext;
      runCnt     <= runNext;
      okCnt      <= okNext;
      alarm      <= (stateNext == ALARM);
      alarmCode  <= codeNext;
      armed      <= (stateNext == IDLE);
      eventCount <= eventNext;
    end
  end

endmodule
